// File: rtl/tage_tagged_bank.sv
// One tagged TAGE bank: hashes PC/history into index+tag, returns a registered
// lookup one cycle later, trains/allocates from commit, clears and ages itself.
module tage_tagged_bank #(
  parameter int DEPTH   = 128,
  parameter int IDXW    = 7,
  parameter int TAGW    = 7,
  parameter int HISTLEN = 8,
  parameter int CTRW    = 3,
  parameter int UW      = 2,
  parameter int ADDRW   = 32,
  parameter int AGEW    = 18
) (
  input  logic              Clk,
  input  logic              Rest,
  output logic              InitDone,
  input  logic              ReadAble,
  input  logic [ADDRW-1:0]  ReadPc,
  input  logic [HISTLEN-1:0] ReadGhr,
  output logic              RespAble,
  output logic              RespHit,
  output logic              RespTaken,
  output logic [CTRW-1:0]   RespCtr,
  output logic [UW-1:0]     RespUseful,
  output logic [IDXW-1:0]   RespIndex,
  output logic [TAGW-1:0]   RespTag,
  input  logic              UpDateAble,
  input  logic              UpDateAlloc,
  input  logic [IDXW-1:0]   UpDateIndex,
  input  logic [TAGW-1:0]   UpDateTag,
  input  logic              UpDateTaken,
  input  logic              UpDateCorrect,
  input  logic              UpDateAltDiffer,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_AGE   = 2'd2;

  localparam logic [CTRW-1:0] CTR_WEAK_T = {1'b1, {(CTRW-1){1'b0}}};
  localparam logic [CTRW-1:0] CTR_WEAK_N = {1'b0, {(CTRW-1){1'b1}}};
  localparam logic [IDXW-1:0] PTR_LAST   = IDXW'(DEPTH - 1);

  // Handshake: a lookup is accepted on any rising edge where ReadAble=1 and the
  // bank is out of INIT; RespAble pulses for exactly the following cycle.
  // Updates have no ready: every UpDateAble outside INIT is applied.

  logic             tbl_valid [DEPTH];
  logic [TAGW-1:0]  tbl_tag   [DEPTH];
  logic [CTRW-1:0]  tbl_ctr   [DEPTH];
  logic [UW-1:0]    tbl_u     [DEPTH];

  logic [1:0]       state;
  logic [IDXW-1:0]  ptr;
  logic [AGEW-1:0]  age_cnt;

  function automatic logic [IDXW-1:0] fold_idx(input logic [HISTLEN-1:0] h);
    logic [IDXW-1:0] r;
    r = '0;
    for (int c = 0; c < HISTLEN; c += IDXW) r = r ^ IDXW'(h >> c);
    return r;
  endfunction

  function automatic logic [TAGW-1:0] fold_tag(input logic [HISTLEN-1:0] h);
    logic [TAGW-1:0] r;
    r = '0;
    for (int c = 0; c < HISTLEN; c += TAGW) r = r ^ TAGW'(h >> c);
    return r;
  endfunction

  function automatic logic [TAGW-2:0] fold_tag1(input logic [HISTLEN-1:0] h);
    logic [TAGW-2:0] r;
    r = '0;
    for (int c = 0; c < HISTLEN; c += TAGW - 1) r = r ^ (TAGW-1)'(h >> c);
    return r;
  endfunction

  logic [IDXW-1:0] rd_idx;
  logic [TAGW-1:0] rd_tag;
  logic            unused_pc_bits;

  always_comb begin
    rd_idx = ReadPc[IDXW+1:2] ^ fold_idx(ReadGhr);
    rd_tag = ReadPc[IDXW+TAGW+1:IDXW+2] ^ fold_tag(ReadGhr) ^ {fold_tag1(ReadGhr), 1'b0};
  end

  assign unused_pc_bits = ^{ReadPc[ADDRW-1:IDXW+TAGW+2], ReadPc[1:0]};

  logic            upd_en;
  logic            age_en;
  logic            rd_en;
  logic            cur_valid;
  logic [TAGW-1:0] cur_tag;
  logic [CTRW-1:0] cur_ctr;
  logic [UW-1:0]   cur_u;
  logic            n_valid;
  logic [TAGW-1:0] n_tag;
  logic [CTRW-1:0] n_ctr;
  logic [UW-1:0]   n_u;

  assign upd_en = UpDateAble && (state != ST_INIT);
  assign rd_en  = ReadAble && (state != ST_INIT);
  // A same-cycle update to the sweep entry takes precedence over halving it.
  assign age_en = (state == ST_AGE) && !(upd_en && (UpDateIndex == ptr));

  assign cur_valid = tbl_valid[UpDateIndex];
  assign cur_tag   = tbl_tag[UpDateIndex];
  assign cur_ctr   = tbl_ctr[UpDateIndex];
  assign cur_u     = tbl_u[UpDateIndex];

  always_comb begin
    n_valid = cur_valid;
    n_tag   = cur_tag;
    n_ctr   = cur_ctr;
    n_u     = cur_u;
    if (UpDateAlloc) begin
      if (cur_u == '0) begin
        n_valid = 1'b1;
        n_tag   = UpDateTag;
        n_u     = '0;
        n_ctr   = UpDateTaken ? CTR_WEAK_T : CTR_WEAK_N;
      end else begin
        n_u = cur_u - 1'b1;
      end
    end else if (cur_valid && (cur_tag == UpDateTag)) begin
      if (UpDateTaken && (cur_ctr != '1)) n_ctr = cur_ctr + 1'b1;
      if (!UpDateTaken && (cur_ctr != '0)) n_ctr = cur_ctr - 1'b1;
      if (UpDateAltDiffer) begin
        if (UpDateCorrect && (cur_u != '1)) n_u = cur_u + 1'b1;
        if (!UpDateCorrect && (cur_u != '0)) n_u = cur_u - 1'b1;
      end
    end
  end

  // Table has no reset of its own: INIT walks every entry after reset.
  always_ff @(posedge Clk) begin
    if (state == ST_INIT) begin
      tbl_valid[ptr] <= 1'b0;
      tbl_tag[ptr]   <= '0;
      tbl_ctr[ptr]   <= '0;
      tbl_u[ptr]     <= '0;
    end else begin
      if (age_en) tbl_u[ptr] <= tbl_u[ptr] >> 1;
      if (upd_en) begin
        tbl_valid[UpDateIndex] <= n_valid;
        tbl_tag[UpDateIndex]   <= n_tag;
        tbl_ctr[UpDateIndex]   <= n_ctr;
        tbl_u[UpDateIndex]     <= n_u;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state      <= ST_INIT;
      ptr        <= '0;
      age_cnt    <= '0;
      RespAble   <= 1'b0;
      RespHit    <= 1'b0;
      RespTaken  <= 1'b0;
      RespCtr    <= '0;
      RespUseful <= '0;
      RespIndex  <= '0;
      RespTag    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) state <= ST_READY;
        end
        ST_READY: begin
          if (upd_en && (age_cnt == '1)) begin
            state <= ST_AGE;
            ptr   <= '0;
          end
        end
        ST_AGE: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) state <= ST_READY;
        end
        default: state <= ST_INIT;
      endcase
      if (upd_en) age_cnt <= age_cnt + 1'b1;
      RespAble <= rd_en;
      if (rd_en) begin
        RespHit    <= tbl_valid[rd_idx] && (tbl_tag[rd_idx] == rd_tag);
        RespTaken  <= tbl_ctr[rd_idx][CTRW-1];
        RespCtr    <= tbl_ctr[rd_idx];
        RespUseful <= tbl_u[rd_idx];
        RespIndex  <= rd_idx;
        RespTag    <= rd_tag;
      end
    end
  end

  assign InitDone  = (state != ST_INIT);
  assign fsm_state = state;

endmodule

// File: tb/tb_tage_tagged_bank.sv
// Bench for tage_tagged_bank: directed scenarios plus random traffic, every
// cycle compared against a spec-level model of the table.
module tb_tage_tagged_bank;

  localparam int DEPTH   = 128;
  localparam int IDXW    = 7;
  localparam int TAGW    = 7;
  localparam int HISTLEN = 8;
  localparam int CTRW    = 3;
  localparam int UW      = 2;
  localparam int ADDRW   = 32;
  localparam int AGEW    = 6;
  localparam int CMAX    = (1 << CTRW) - 1;
  localparam int UMAX    = (1 << UW) - 1;

  logic               Clk;
  logic               Rest;
  logic               InitDone;
  logic               ReadAble;
  logic [ADDRW-1:0]   ReadPc;
  logic [HISTLEN-1:0] ReadGhr;
  logic               RespAble;
  logic               RespHit;
  logic               RespTaken;
  logic [CTRW-1:0]    RespCtr;
  logic [UW-1:0]      RespUseful;
  logic [IDXW-1:0]    RespIndex;
  logic [TAGW-1:0]    RespTag;
  logic               UpDateAble;
  logic               UpDateAlloc;
  logic [IDXW-1:0]    UpDateIndex;
  logic [TAGW-1:0]    UpDateTag;
  logic               UpDateTaken;
  logic               UpDateCorrect;
  logic               UpDateAltDiffer;
  logic [1:0]         fsm_state;

  tage_tagged_bank #(
    .DEPTH(DEPTH), .IDXW(IDXW), .TAGW(TAGW), .HISTLEN(HISTLEN),
    .CTRW(CTRW), .UW(UW), .ADDRW(ADDRW), .AGEW(AGEW)
  ) dut (
    .Clk(Clk), .Rest(Rest), .InitDone(InitDone),
    .ReadAble(ReadAble), .ReadPc(ReadPc), .ReadGhr(ReadGhr),
    .RespAble(RespAble), .RespHit(RespHit), .RespTaken(RespTaken),
    .RespCtr(RespCtr), .RespUseful(RespUseful), .RespIndex(RespIndex),
    .RespTag(RespTag), .UpDateAble(UpDateAble), .UpDateAlloc(UpDateAlloc),
    .UpDateIndex(UpDateIndex), .UpDateTag(UpDateTag), .UpDateTaken(UpDateTaken),
    .UpDateCorrect(UpDateCorrect), .UpDateAltDiffer(UpDateAltDiffer),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  bit m_valid [DEPTH];
  int m_tag   [DEPTH];
  int m_ctr   [DEPTH];
  int m_u     [DEPTH];
  bit m_ready;
  int m_init_cnt;
  bit m_aging;
  int m_ptr;
  int m_age_cnt;
  int e_able, e_hit, e_taken, e_ctr, e_u, e_idx, e_tag;

  int unsigned pc_set  [4] = '{32'h1C00, 32'h1C80, 32'h2F44, 32'h0A10};
  int unsigned ghr_set [4] = '{32'h5A, 32'h00, 32'hC3, 32'h17};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic int fold(input int unsigned h, input int w);
    int unsigned acc;
    acc = 0;
    for (int c = 0; c < HISTLEN; c += w) acc = acc ^ ((h >> c) & ((1 << w) - 1));
    return int'(acc);
  endfunction

  function automatic int hidx(input int unsigned pc, input int unsigned ghr);
    return int'((pc >> 2) & (DEPTH - 1)) ^ fold(ghr, IDXW);
  endfunction

  function automatic int htag(input int unsigned pc, input int unsigned ghr);
    return int'((pc >> (IDXW + 2)) & ((1 << TAGW) - 1)) ^ fold(ghr, TAGW) ^ (fold(ghr, TAGW - 1) << 1);
  endfunction

  function automatic void model_update();
    int i;
    i = int'(UpDateIndex);
    if (UpDateAlloc) begin
      if (m_u[i] == 0) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = int'(UpDateTag);
        m_u[i]     = 0;
        m_ctr[i]   = UpDateTaken ? (1 << (CTRW - 1)) : (1 << (CTRW - 1)) - 1;
      end else begin
        m_u[i] = m_u[i] - 1;
      end
    end else if (m_valid[i] && m_tag[i] == int'(UpDateTag)) begin
      if (UpDateTaken) m_ctr[i] = (m_ctr[i] == CMAX) ? CMAX : m_ctr[i] + 1;
      else             m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      if (UpDateAltDiffer) begin
        if (UpDateCorrect) m_u[i] = (m_u[i] == UMAX) ? UMAX : m_u[i] + 1;
        else               m_u[i] = (m_u[i] == 0) ? 0 : m_u[i] - 1;
      end
    end
  endfunction

  // One clock: advance the model with the driven inputs, then compare.
  task automatic tick();
    int idx, tag;
    bit upd, was_aging;
    e_able = 0;
    if (m_ready && ReadAble) begin
      idx    = hidx(ReadPc, int'(ReadGhr));
      tag    = htag(ReadPc, int'(ReadGhr));
      e_able = 1;
      e_hit  = (m_valid[idx] && m_tag[idx] == tag) ? 1 : 0;
      e_ctr  = m_ctr[idx];
      e_taken = (m_ctr[idx] >= (1 << (CTRW - 1))) ? 1 : 0;
      e_u    = m_u[idx];
      e_idx  = idx;
      e_tag  = tag;
    end
    upd = m_ready && UpDateAble;
    was_aging = m_aging;
    if (m_aging) begin
      if (!(upd && int'(UpDateIndex) == m_ptr)) m_u[m_ptr] = m_u[m_ptr] / 2;
      m_ptr++;
      if (m_ptr == DEPTH) m_aging = 1'b0;
    end
    if (upd) begin
      model_update();
      if (m_age_cnt == (1 << AGEW) - 1) begin
        m_age_cnt = 0;
        if (!was_aging) begin
          m_aging = 1'b1;
          m_ptr   = 0;
        end
      end else begin
        m_age_cnt++;
      end
    end
    if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          m_valid[i] = 1'b0; m_tag[i] = 0; m_ctr[i] = 0; m_u[i] = 0;
        end
      end
    end
    @(posedge Clk);
    #1;
    check("resp_able", RespAble, e_able);
    check("init_done", InitDone, m_ready);
    check("resp_hit", RespHit, e_hit);
    check("resp_taken", RespTaken, e_taken);
    check("resp_ctr", RespCtr, e_ctr);
    check("resp_useful", RespUseful, e_u);
    check("resp_index", RespIndex, e_idx);
    check("resp_tag", RespTag, e_tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic look(input int unsigned pc, input int unsigned ghr);
    ReadAble = 1'b1;
    ReadPc   = pc;
    ReadGhr  = HISTLEN'(ghr);
    tick();
    ReadAble = 1'b0;
  endtask

  task automatic upd(input bit alloc, input int idx, input int tag,
                     input bit taken, input bit correct, input bit altd);
    UpDateAble      = 1'b1;
    UpDateAlloc     = alloc;
    UpDateIndex     = IDXW'(idx);
    UpDateTag       = TAGW'(tag);
    UpDateTaken     = taken;
    UpDateCorrect   = correct;
    UpDateAltDiffer = altd;
    tick();
    UpDateAble = 1'b0;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_init_done"}, InitDone, 0);
    check({pfx, "_resp_able"}, RespAble, 0);
    check({pfx, "_resp_hit"}, RespHit, 0);
    check({pfx, "_resp_taken"}, RespTaken, 0);
    check({pfx, "_resp_ctr"}, RespCtr, 0);
    check({pfx, "_resp_useful"}, RespUseful, 0);
    check({pfx, "_resp_index"}, RespIndex, 0);
    check({pfx, "_resp_tag"}, RespTag, 0);
  endtask

  task automatic model_reset();
    m_ready = 1'b0; m_init_cnt = 0; m_aging = 1'b0; m_ptr = 0; m_age_cnt = 0;
    e_able = 0; e_hit = 0; e_taken = 0; e_ctr = 0; e_u = 0; e_idx = 0; e_tag = 0;
  endtask

  task automatic run_init();
    for (int c = 1; c <= DEPTH; c++) begin
      if (c == 50) begin
        look(pc_set[0], ghr_set[0]);
        check("init_lookup_ignored", RespAble, 0);
      end else begin
        tick();
      end
      if (c == DEPTH - 1) check("init_done_at_127", InitDone, 0);
      if (c == DEPTH) check("init_done_at_128", InitDone, 1);
    end
  endtask

  task automatic rand_cycle();
    int r, s, r2, s2, tag;
    r = $urandom_range(0, 3); s = $urandom_range(0, 3);
    r2 = $urandom_range(0, 3); s2 = $urandom_range(0, 3);
    ReadAble = 1'($urandom_range(0, 1));
    ReadPc   = pc_set[r];
    ReadGhr  = HISTLEN'(ghr_set[s]);
    tag = htag(pc_set[r2], ghr_set[s2]);
    if ($urandom_range(0, 3) == 0) tag = tag ^ int'($urandom_range(1, (1 << TAGW) - 1));
    UpDateAble      = ($urandom_range(0, 2) != 0);
    UpDateAlloc     = ($urandom_range(0, 3) == 0);
    UpDateIndex     = IDXW'(hidx(pc_set[r2], ghr_set[s2]));
    UpDateTag       = TAGW'(tag);
    UpDateTaken     = 1'($urandom_range(0, 1));
    UpDateCorrect   = 1'($urandom_range(0, 1));
    UpDateAltDiffer = 1'($urandom_range(0, 1));
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned pc0, pc1, ghr;
    int idx0, tag0, idx1, tag1;
    Rest = 1'b1; ReadAble = 1'b0; ReadPc = '0; ReadGhr = '0;
    UpDateAble = 1'b0; UpDateAlloc = 1'b0; UpDateIndex = '0; UpDateTag = '0;
    UpDateTaken = 1'b0; UpDateCorrect = 1'b0; UpDateAltDiffer = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_zero_outputs("reset");
    Rest = 1'b0;
    run_init();

    pc0 = 32'h1C00; pc1 = 32'h1C80; ghr = 32'h5A;
    idx0 = hidx(pc0, ghr); tag0 = htag(pc0, ghr);
    idx1 = hidx(pc1, ghr); tag1 = htag(pc1, ghr);

    // allocate then look up
    upd(1, idx0, tag0, 1, 0, 0);
    look(pc0, ghr);
    check("alloc_hit", RespHit, 1);
    check("alloc_ctr", RespCtr, 4);
    check("alloc_useful", RespUseful, 0);
    check("alloc_taken", RespTaken, 1);
    check("alloc_index", RespIndex, 7'h5A);
    check("alloc_tag", RespTag, 7'h62);

    // counter saturation both ways
    repeat (5) upd(0, idx0, tag0, 1, 0, 0);
    look(pc0, ghr);
    check("ctr_sat_hi", RespCtr, 7);
    repeat (8) upd(0, idx0, tag0, 0, 0, 0);
    look(pc0, ghr);
    check("ctr_sat_lo", RespCtr, 0);
    check("ctr_lo_taken", RespTaken, 0);

    // useful training, then blocked allocation
    repeat (4) upd(0, idx0, tag0, 0, 1, 1);
    look(pc0, ghr);
    check("useful_sat", RespUseful, 3);
    upd(1, idx0, tag0 ^ 1, 1, 0, 0);
    look(pc0, ghr);
    check("alloc_blocked_u", RespUseful, 2);
    check("alloc_blocked_hit", RespHit, 1);
    look(pc0 ^ 32'h200, ghr);
    check("new_tag_miss", RespHit, 0);

    // second entry with u=3, refresh first to u=3
    upd(1, idx1, tag1, 1, 0, 0);
    repeat (3) upd(0, idx1, tag1, 1, 1, 1);
    upd(0, idx0, tag0, 0, 1, 1);

    // drive updates until the age counter wraps
    for (int i = 0; i < 200 && !m_aging; i++) upd(0, 3, 0, 0, 0, 0);
    check("age_entered", m_aging, 1);
    ReadAble = 1'b1; ReadPc = pc0; ReadGhr = HISTLEN'(ghr);
    for (int i = 0; i < DEPTH + 4 && m_aging; i++) begin
      if (m_ptr == idx1) upd(0, idx1, tag1, 1, 1, 1);
      else tick();
    end
    ReadAble = 1'b0;
    check("age_left", m_aging, 0);
    look(pc0, ghr);
    check("aged_useful", RespUseful, 1);
    look(pc1, ghr);
    check("collide_useful", RespUseful, 3);

    // random traffic
    for (int i = 0; i < 1500; i++) rand_cycle();
    ReadAble = 1'b0; UpDateAble = 1'b0;

    // reset in the middle of a sweep
    for (int i = 0; i < 400 && !(m_aging && m_ptr == 40); i++) begin
      UpDateAble = !m_aging; UpDateAlloc = 1'b0; UpDateIndex = 7'd3; UpDateTag = '0;
      tick();
    end
    UpDateAble = 1'b0;
    check("age_ptr_40", (m_aging && m_ptr == 40), 1);
    Rest = 1'b1;
    #2;
    check_zero_outputs("mid_age_reset");
    model_reset();
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rest = 1'b0;
    run_init();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        look(pc_set[a], ghr_set[b]);
        check("post_reset_hit", RespHit, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tage_tagged_bank.md
Name: tage_tagged_bank

Overview:
- One parametrised tagged TAGE component, instanced N times with different history lengths to form the tagged tables of the branch predictor.
- Hashes PC and global history into an index and a tag, and returns a registered hit/prediction one cycle after a lookup.
- Applies provider training and entry allocation from the commit-side update port.
- Runs its own post-reset table clear and a periodic useful-bit aging sweep.
- Storage is a flop array, so update read-modify-write completes in a single cycle.

Parameters:
- DEPTH, 128, number of entries, power of two.
- IDXW, 7, index width, equal to log2(DEPTH).
- TAGW, 7, stored tag width.
- HISTLEN, 8, global-history bits consumed by this bank.
- CTRW, 3, prediction counter width.
- UW, 2, useful counter width.
- ADDRW, 32, PC width.
- AGEW, 18, aging period counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Rest  in  1  reset, asynchronous, active-high.
- InitDone  out  1  high once the table clear has finished.
- ReadAble  in  1  lookup request.
- ReadPc  in  ADDRW  lookup PC.
- ReadGhr  in  HISTLEN  lookup history; bit 0 is the newest branch.
- RespAble  out  1  response valid; exactly one cycle after an accepted lookup.
- RespHit  out  1  entry is valid and its tag matches.
- RespTaken  out  1  counter MSB of the looked-up entry.
- RespCtr  out  CTRW  stored counter value.
- RespUseful  out  UW  stored useful value.
- RespIndex  out  IDXW  computed index, for use at update.
- RespTag  out  TAGW  computed tag, for use at update.
- UpDateAble  in  1  update strobe.
- UpDateAlloc  in  1  1 = allocate, 0 = provider train.
- UpDateIndex  in  IDXW  target entry.
- UpDateTag  in  TAGW  tag to match or to write.
- UpDateTaken  in  1  resolved branch direction.
- UpDateCorrect  in  1  final prediction was correct.
- UpDateAltDiffer  in  1  provider and alternate predictions differed.

Behaviour:
- Entry contents: {valid, tag[TAGW], ctr[CTRW], u[UW]}.
- Hash rule:
  - fold(h,W) = XOR of consecutive W-bit chunks of h; the last chunk is zero-padded.
  - index = ReadPc[IDXW+1:2] ^ fold(ReadGhr,IDXW).
  - tag = ReadPc[IDXW+TAGW+1:IDXW+2] ^ fold(ReadGhr,TAGW) ^ {fold(ReadGhr,TAGW-1),1'b0}.
- FSM states: INIT, READY, AGE.
- Reset (async, Rest=1):
  - state <= INIT; sweep pointer <= 0; age counter <= 0.
  - InitDone=0; RespAble=0; all other Resp* outputs = 0.
  - Reset mid-sweep or mid-lookup aborts it; the next response is only produced after a new INIT completes.
- INIT:
  - Clears one entry per cycle (all fields 0), pointer 0 to DEPTH-1.
  - Goes to READY after the clear of entry DEPTH-1; InitDone rises exactly DEPTH cycles after Rest falls.
  - Lookups and updates are ignored; RespAble stays 0.
- Lookup, in READY or AGE:
  - Resp* is registered 1 cycle after ReadAble; RespAble=0 in cycles with no lookup.
  - Resp* fields hold their last value when RespAble=0.
  - A lookup and an update to the same index in the same cycle: the response shows the pre-update contents.
- Provider train (UpDateAble=1, Alloc=0), applied only if entry.valid and entry.tag==UpDateTag; otherwise no change:
  - ctr saturating +1 if taken, -1 if not taken, clamped to [0, 2^CTRW-1].
  - If AltDiffer: u saturating +1 if Correct, else saturating -1.
- Allocate (UpDateAble=1, Alloc=1):
  - If entry.u==0: write valid=1, tag=UpDateTag, u=0, ctr = 2^(CTRW-1) if taken, else 2^(CTRW-1)-1.
  - Else: u saturating -1, and the entry is otherwise untouched.
- Aging:
  - The age counter increments on each UpDateAble in READY or AGE.
  - At all-ones it wraps to 0 and the FSM enters AGE.
  - AGE halves u (u>>1) of one entry per cycle, pointer 0 to DEPTH-1, then returns to READY.
  - If an update targets the sweep-pointer entry in the same cycle, the update wins and that entry is not aged; the pointer still advances.
  - Overflow while already in AGE is ignored; the counter still wraps.
- Updates are never back-pressured; at most one update per cycle.

Test Plan:
- Release Rest -> InitDone=0 for cycles 1..127 and InitDone=1 at cycle 128; a lookup issued at cycle 50 produces RespAble=0.
- Allocate PC=0x1C00, GHR=0x5A, taken -> a lookup one cycle later returns Hit=1, Ctr=4, Useful=0, Taken=1, with RespIndex/RespTag equal to the hash rule values.
- Provider train on the same entry taken x5 -> Ctr saturates at 7; then not-taken x8 -> Ctr=0, Taken=0.
- AltDiffer=1, Correct=1 x4 -> u=3; then Allocate to the same index with a different tag -> u=2 and the tag is unchanged; lookup with the new tag -> Hit=0.
- Force the age counter to all-ones and send one update -> AGE lasts 128 cycles and an entry with u=3 becomes u=1; an update to the pointer entry in the same cycle keeps its trained u.
- Assert Rest during AGE at pointer 40 -> all outputs 0 immediately, INIT restarts, and all entries read Hit=0 afterwards.
